// File: rtl/hash_target_check_if.sv
// ---------------------------------------------------------------------------
// hash_target_check_if
// Bundles the hash-input handshake and the verdict/status outputs of
// hash_target_check.
//   master : the miner/consumer side (drives hash_in, hash_valid, nonce_in,
//            nbits, result_ready; observes everything else)
//   slave  : the checker block itself
// Signals:
//   hash_in[255:0]   raw double-SHA256 digest, digest byte 0 in [255:248]
//   hash_valid       hash_in/nonce_in/nbits valid this cycle
//   hash_ready       checker can accept a hash
//   nonce_in[31:0]   nonce that produced hash_in
//   nbits[31:0]      compact target in numeric order
//   result_valid     verdict available
//   result_ready     consumer takes the verdict
//   meets_target     1 when hash <= target
//   invalid_nbits    captured nbits was unusable
//   found            sticky: some accepted hash met its target
//   found_nonce      nonce of the first passing hash
//   hash_count       number of hashes accepted (wraps)
// ---------------------------------------------------------------------------
interface hash_target_check_if #(
    parameter int COUNT_W = 32
);
    logic [255:0]       hash_in;
    logic               hash_valid;
    logic               hash_ready;
    logic [31:0]        nonce_in;
    logic [31:0]        nbits;
    logic               result_valid;
    logic               result_ready;
    logic               meets_target;
    logic               invalid_nbits;
    logic               found;
    logic [31:0]        found_nonce;
    logic [COUNT_W-1:0] hash_count;

    modport master (
        output hash_in, hash_valid, nonce_in, nbits, result_ready,
        input  hash_ready, result_valid, meets_target, invalid_nbits,
               found, found_nonce, hash_count
    );

    modport slave (
        input  hash_in, hash_valid, nonce_in, nbits, result_ready,
        output hash_ready, result_valid, meets_target, invalid_nbits,
               found, found_nonce, hash_count
    );
endinterface

// File: rtl/hash_target_check.sv
// ---------------------------------------------------------------------------
// hash_target_check
// Decides whether a miner's double-SHA256 result satisfies the compact
// (nbits) difficulty target.  One hash is in flight at a time:
//   IDLE    : hash_ready=1, waits for hash_valid; captures hash/nonce/nbits
//   EXPAND  : one cycle, turns nbits into a 256-bit target and flags
//             unusable encodings
//   COMPARE : four cycles, one 64-bit limb per cycle from MSB to LSB; the
//             first unequal limb decides, equal limbs leave it open
//   DONE    : publishes the verdict and holds it until result_ready
// Verdict latency is fixed: accept at edge N gives result_valid after N+6.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-low reset
//   bus  - hash_target_check_if.slave (handshakes, verdict, status)
// COUNT_W must match the COUNT_W of the connected interface instance.
// ---------------------------------------------------------------------------
module hash_target_check #(
    parameter int COUNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    hash_target_check_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXPAND  = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // The digest arrives as a byte string; numeric comparison treats the
    // last digest byte as the most significant one.
    function automatic logic [255:0] byte_reverse(input logic [255:0] d);
        logic [255:0] r;
        r = 256'd0;
        for (int i = 0; i < 32; i++) begin
            r[8*i +: 8] = d[255-8*i -: 8];
        end
        return r;
    endfunction

    state_t             r_state;
    state_t             w_state_next;

    logic [255:0]       r_hash;         // numeric H (already byte-reversed)
    logic [31:0]        r_nonce;
    logic [31:0]        r_nbits;
    logic [COUNT_W-1:0] r_count;

    logic [255:0]       r_target;
    logic               r_bad_nbits;
    logic [1:0]         r_limb_idx;     // limb being compared, 3 = MSB limb
    logic               r_decided;      // an unequal limb has been seen
    logic               r_below;        // H < T at the deciding limb

    logic               r_hash_ready;
    logic               r_result_valid;
    logic               r_meets;
    logic               r_invalid;
    logic               r_found;
    logic [31:0]        r_found_nonce;

    logic               w_accept;
    logic [7:0]         w_exp;
    logic [23:0]        w_mant;
    logic [255:0]       w_mant_ext;
    logic [10:0]        w_shift;
    logic [255:0]       w_target;
    logic               w_bad;
    logic [63:0]        w_h_limb;
    logic [63:0]        w_t_limb;
    logic               w_verdict;

    // hash_ready only ever asserts in IDLE, so this is the accept condition.
    assign w_accept   = bus.hash_valid && (r_state == IDLE);

    assign w_exp      = r_nbits[31:24];
    assign w_mant     = r_nbits[23:0];
    assign w_mant_ext = {232'd0, w_mant};

    // Sign bit set, zero mantissa or an exponent past the 256-bit range
    // make the target meaningless.
    assign w_bad      = r_nbits[23] || (w_mant == 24'd0) || (w_exp > 8'd32);

    assign w_h_limb   = r_hash[{r_limb_idx, 6'd0} +: 64];
    assign w_t_limb   = r_target[{r_limb_idx, 6'd0} +: 64];

    // All limbs equal means H == T, which passes; a bad nbits never passes.
    assign w_verdict  = !r_bad_nbits && (!r_decided || r_below);

    // Target expansion: mantissa shifted by whole bytes around exponent 3.
    // Shifts of 256 bits or more yield zero, which drops overflowing bits.
    always_comb begin
        w_shift  = 11'd0;
        w_target = 256'd0;
        if (w_exp >= 8'd3) begin
            w_shift  = ({3'b000, w_exp} - 11'd3) << 3;
            w_target = w_mant_ext << w_shift;
        end else begin
            w_shift  = (11'd3 - {3'b000, w_exp}) << 3;
            w_target = w_mant_ext >> w_shift;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = EXPAND;
                end else begin
                    w_state_next = IDLE;
                end
            end
            EXPAND: begin
                w_state_next = COMPARE;
            end
            COMPARE: begin
                if (r_limb_idx == 2'd0) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = COMPARE;
                end
            end
            DONE: begin
                if (r_result_valid && bus.result_ready) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = DONE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // hash_ready registered from the next state so it tracks IDLE exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hash_ready <= 1'b1;
        end else begin
            r_hash_ready <= (w_state_next == IDLE);
        end
    end

    // Input capture and accepted-hash counter (wraps naturally).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hash  <= 256'd0;
            r_nonce <= 32'd0;
            r_nbits <= 32'd0;
            r_count <= {COUNT_W{1'b0}};
        end else if (w_accept) begin
            r_hash  <= byte_reverse(bus.hash_in);
            r_nonce <= bus.nonce_in;
            r_nbits <= bus.nbits;
            r_count <= r_count + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Target expansion register and the limb-serial compare.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_target    <= 256'd0;
            r_bad_nbits <= 1'b0;
            r_limb_idx  <= 2'd3;
            r_decided   <= 1'b0;
            r_below     <= 1'b0;
        end else begin
            case (r_state)
                EXPAND: begin
                    r_target    <= w_target;
                    r_bad_nbits <= w_bad;
                    r_limb_idx  <= 2'd3;
                    r_decided   <= 1'b0;
                    r_below     <= 1'b0;
                end
                COMPARE: begin
                    r_limb_idx <= r_limb_idx - 2'd1;
                    // Once decided, lower limbs are walked but ignored so the
                    // latency never depends on the data.
                    if (!r_decided && (w_h_limb != w_t_limb)) begin
                        r_decided <= 1'b1;
                        r_below   <= (w_h_limb < w_t_limb);
                    end
                end
                default: begin
                    r_limb_idx <= r_limb_idx;
                end
            endcase
        end
    end

    // Verdict publication on the first DONE cycle, sticky found tracking,
    // and result handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result_valid <= 1'b0;
            r_meets        <= 1'b0;
            r_invalid      <= 1'b0;
            r_found        <= 1'b0;
            r_found_nonce  <= 32'd0;
        end else if ((r_state == DONE) && !r_result_valid) begin
            r_result_valid <= 1'b1;
            r_meets        <= w_verdict;
            r_invalid      <= r_bad_nbits;
            // Only the first passing nonce is remembered.
            if (w_verdict && !r_found) begin
                r_found       <= 1'b1;
                r_found_nonce <= r_nonce;
            end
        end else if (r_result_valid && bus.result_ready) begin
            r_result_valid <= 1'b0;
        end
    end

    assign bus.hash_ready    = r_hash_ready;
    assign bus.result_valid  = r_result_valid;
    assign bus.meets_target  = r_meets;
    assign bus.invalid_nbits = r_invalid;
    assign bus.found         = r_found;
    assign bus.found_nonce   = r_found_nonce;
    assign bus.hash_count    = r_count;

endmodule

// File: tb/tb_hash_target_check.sv
// ---------------------------------------------------------------------------
// tb_hash_target_check
// Scoreboard bench for hash_target_check.  The driver pushes the expected
// verdict for every accepted hash; an independent monitor pops and compares
// when result_valid rises.  A narrow hash counter (4 bits) exercises wrap.
// ---------------------------------------------------------------------------
module tb_hash_target_check;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hash_target_check_if #(.COUNT_W(CW)) bus ();

    hash_target_check #(.COUNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          meets;
        logic          invalid;
        logic          found;
        logic [31:0]   fnonce;
        logic [CW-1:0] count;
        int            rise_cyc;
    } exp_t;

    exp_t          q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc   = 0;
    logic          m_found = 1'b0;
    logic [31:0]   m_fnonce = 32'd0;
    logic [CW-1:0] m_count = '0;
    int            last_accept = 0;
    logic          prev_rv = 1'b0;

    // Edge counter: at a falling edge cyc equals the index of the last rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Digest byte i (bits [255-8i -: 8]) becomes numeric byte i (LSB first).
    function automatic logic [255:0] brev(input logic [255:0] d);
        logic [255:0] r;
        r = 256'd0;
        for (int i = 0; i < 32; i++) r = (r << 8) | ((d >> (8 * i)) & 256'hff);
        return r;
    endfunction

    // Target from compact form, by repeated multiplication/division by 256.
    function automatic logic [255:0] target_of(input logic [31:0] nb);
        logic [255:0] t;
        int e;
        e = int'(nb[31:24]);
        t = 256'(nb[23:0]);
        if (e >= 3) begin
            for (int k = 0; k < e - 3; k++) t = t * 256;
        end else begin
            for (int k = 0; k < 3 - e; k++) t = t / 256;
        end
        return t;
    endfunction

    function automatic logic bad_of(input logic [31:0] nb);
        return nb[23] || (nb[23:0] == 24'd0) || (int'(nb[31:24]) > 32);
    endfunction

    // Present one hash (numeric value h) and wait for it to be accepted.
    task automatic send(input logic [255:0] h, input logic [31:0] nonce, input logic [31:0] nb,
                        input bit hold, input bit rnd_rr, output int waited);
        exp_t e;
        logic bad;
        logic meets;
        bus.hash_in    = brev(h);
        bus.nonce_in   = nonce;
        bus.nbits      = nb;
        bus.hash_valid = 1'b1;
        waited = 0;
        while (!bus.hash_ready && waited < 200) begin
            if (rnd_rr) bus.result_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            waited++;
        end
        if (!bus.hash_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: hash_ready stayed 0, expected 1");
            bus.hash_valid = 1'b0;
            return;
        end
        bad   = bad_of(nb);
        meets = !bad && (h <= target_of(nb));
        m_count = m_count + 1'b1;
        if (meets && !m_found) begin
            m_found  = 1'b1;
            m_fnonce = nonce;
        end
        e.meets    = meets;
        e.invalid  = bad;
        e.found    = m_found;
        e.fnonce   = m_fnonce;
        e.count    = m_count;
        e.rise_cyc = cyc + 1 + 6;
        q.push_back(e);
        last_accept = cyc + 1;
        @(negedge clk);
        // Scramble inputs after accept: the verdict must not follow them.
        bus.hash_in  = {$urandom(), $urandom(), $urandom(), $urandom(),
                        $urandom(), $urandom(), $urandom(), $urandom()};
        bus.nonce_in = $urandom();
        bus.nbits    = $urandom();
        if (!hold) bus.hash_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.result_ready = 1'b1;
        while ((q.size() != 0 || bus.result_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
        end
    endtask

    // Monitor: compare each published verdict against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (bus.result_valid && !prev_rv) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: result_valid=1 with no hash outstanding");
            end else begin
                e = q.pop_front();
                check("latency",       256'(cyc),             256'(e.rise_cyc));
                check("meets_target",  256'(bus.meets_target),  256'(e.meets));
                check("invalid_nbits", 256'(bus.invalid_nbits), 256'(e.invalid));
                check("found",         256'(bus.found),         256'(e.found));
                check("found_nonce",   256'(bus.found_nonce),   256'(e.fnonce));
                check("hash_count",    256'(bus.hash_count),    256'(e.count));
            end
        end
        prev_rv = bus.result_valid;
    end

    // Global time limit.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Main stimulus.
    initial begin
        logic [255:0] h;
        logic [31:0]  nb;
        logic         bp_meets;
        int           w;
        int           rel_edge;
        int           rv_seen;

        bus.hash_in      = 256'd0;
        bus.hash_valid   = 1'b0;
        bus.nonce_in     = 32'd0;
        bus.nbits        = 32'd0;
        bus.result_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_result_valid", 256'(bus.result_valid), 256'd0);
        check("rst_meets",        256'(bus.meets_target), 256'd0);
        check("rst_found",        256'(bus.found),        256'd0);
        check("rst_found_nonce",  256'(bus.found_nonce),  256'd0);
        check("rst_hash_count",   256'(bus.hash_count),   256'd0);
        rst = 1'b1;
        check("rst_hash_ready",   256'(bus.hash_ready),   256'd1);

        // Known pass case; accepted on the first edge after release.
        send(256'h000000000003ba27aa200b1cecaad478d2b00432346c3f1f3986da1afd33e506,
             32'h4c86041b, 32'h1b04864c, 1'b0, 1'b0, w);
        check("first_accept_wait", 256'(w), 256'd0);
        // Just above the target: fails.
        send(256'h0000000000048650 << 192, 32'h00000002, 32'h1b04864c, 1'b0, 1'b0, w);
        // Exactly on the target: passes.
        send(target_of(32'h1b04864c), 32'h00000003, 32'h1b04864c, 1'b0, 1'b0, w);
        // Sign-bit nbits is invalid even for a zero hash.
        send(256'd0, 32'h00000004, 32'h1d800000, 1'b0, 1'b0, w);
        // Small exponents shift the mantissa right.
        send(256'h1234, 32'h5, 32'h02123456, 1'b0, 1'b0, w);
        send(256'h1235, 32'h6, 32'h02123456, 1'b0, 1'b0, w);
        send(256'h12,   32'h7, 32'h01123456, 1'b0, 1'b0, w);
        // Exponent 32 is the largest valid one; 33 and zero mantissa are not.
        send(target_of(32'h207fffff), 32'h8, 32'h207fffff, 1'b0, 1'b0, w);
        send(256'd0, 32'h9, 32'h21010000, 1'b0, 1'b0, w);
        send(256'd0, 32'ha, 32'h1b000000, 1'b0, 1'b0, w);
        drain();

        // Backpressure: verdict held, further hash_valid ignored.
        bus.result_ready = 1'b0;
        h  = 256'h1 << 100;
        nb = 32'h1d00ffff;
        bp_meets = !bad_of(nb) && (h <= target_of(nb));
        send(h, 32'h0000bbbb, nb, 1'b1, 1'b0, w);
        w = 0;
        while (!bus.result_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 10; i++) begin
            check("bp_result_valid", 256'(bus.result_valid), 256'd1);
            check("bp_hash_ready",   256'(bus.hash_ready),   256'd0);
            check("bp_meets",        256'(bus.meets_target), 256'(bp_meets));
            check("bp_hash_count",   256'(bus.hash_count),   256'(m_count));
            @(negedge clk);
        end
        bus.result_ready = 1'b1;
        rel_edge = cyc + 1;
        send(256'd5, 32'h0000cccc, 32'h1d00ffff, 1'b0, 1'b0, w);
        check("bp_next_accept_edge", 256'(last_accept), 256'(rel_edge + 1));
        drain();

        // Reset in the middle of COMPARE.
        send(256'd1, 32'h0000dddd, 32'h1d00ffff, 1'b0, 1'b0, w);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_found  = 1'b0;
        m_fnonce = 32'd0;
        m_count  = '0;
        #1;
        check("mid_rst_result_valid", 256'(bus.result_valid),  256'd0);
        check("mid_rst_meets",        256'(bus.meets_target),  256'd0);
        check("mid_rst_invalid",      256'(bus.invalid_nbits), 256'd0);
        check("mid_rst_found",        256'(bus.found),         256'd0);
        check("mid_rst_found_nonce",  256'(bus.found_nonce),   256'd0);
        check("mid_rst_hash_count",   256'(bus.hash_count),    256'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rv_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.result_valid) rv_seen++;
        end
        check("post_rst_no_result", 256'(rv_seen), 256'd0);

        // Sticky found_nonce: the second passing nonce must not replace it.
        send(256'd7, 32'h00000011, 32'h1d00ffff, 1'b0, 1'b0, w);
        send(256'd9, 32'h00000022, 32'h1d00ffff, 1'b0, 1'b0, w);
        drain();
        check("sticky_found_nonce", 256'(bus.found_nonce), 256'h11);

        // Randomized traffic with random consumer backpressure; the count
        // passes 16 accepts here and wraps.
        for (int i = 0; i < 40; i++) begin
            logic [255:0] t;
            nb[31:24] = 8'($urandom_range(0, 34));
            nb[23:0]  = 24'($urandom());
            if ($urandom_range(0, 3) != 0) nb[23] = 1'b0;
            t = target_of(nb);
            case ($urandom_range(0, 4))
                0: h = {$urandom(), $urandom(), $urandom(), $urandom(),
                        $urandom(), $urandom(), $urandom(), $urandom()};
                1: h = t;
                2: h = t + 256'($urandom_range(1, 3));
                3: h = t - 256'($urandom_range(1, 3));
                default: h = t ^ (256'd1 << $urandom_range(0, 255));
            endcase
            send(h, $urandom(), nb, 1'b0, 1'b1, w);
        end
        drain();
        check("final_hash_count", 256'(bus.hash_count), 256'(m_count));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
